// File: rtl/multi_sync_event.sv
// ---------------------------------------------------------------------------
// multi_sync_event
//
// Purpose:
//   Synchronises CH asynchronous inputs into the clk domain through a
//   STAGES-deep flop chain. It detects edges on the synchronised levels
//   (rising, falling or both, chosen by EDGE_MODE) and collects them into
//   an event mask. The mask is offered to a single consumer on a
//   valid/ready interface.
//   If a channel sees an edge while an earlier edge on the same channel is
//   still waiting behind a stalled mask, the two edges merge into one bit
//   and that channel's sticky overflow flag is set.
//
// Parameters:
//   CH        number of channels
//   STAGES    synchroniser depth (>= 2)
//   EDGE_MODE 0 = rising, 1 = falling, 2 = both edges
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous reset, active low
//   ena        high: synchroniser chain advances and edges are generated
//   async_in   [CH] asynchronous inputs
//   sync_out   [CH] synchronised level (last chain stage)
//   evt_data   [CH] event mask
//   evt_valid  evt_data holds an unconsumed mask
//   evt_ready  consumer accepts evt_data
//   ovf        [CH] sticky per-channel overflow
//   ovf_clr    clear all ovf bits
//
// Handshake: a mask transfers on any clk edge where evt_valid and evt_ready
// are both high. While evt_valid is high and evt_ready is low, evt_data and
// evt_valid are held unchanged. Once evt_valid rises, it stays high until the
// transfer happens.
// ---------------------------------------------------------------------------
module multi_sync_event #(
    parameter int CH        = 8,
    parameter int STAGES    = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [CH-1:0] async_in,
    output logic [CH-1:0] sync_out,
    output logic [CH-1:0] evt_data,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [CH-1:0] ovf,
    input  logic          ovf_clr
);

    if (STAGES < 2) begin : g_bad_stages
        $error("multi_sync_event: STAGES must be at least 2");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
        $error("multi_sync_event: EDGE_MODE must be 0, 1 or 2");
    end

    logic [CH-1:0] r_sync [STAGES];
    logic [CH-1:0] r_d;
    logic [CH-1:0] r_pending;
    logic [CH-1:0] r_evt_data;
    logic          r_evt_valid;
    logic [CH-1:0] r_ovf;

    logic [CH-1:0] w_last;
    logic [CH-1:0] w_raw_edge;
    logic [CH-1:0] w_edge;
    logic [CH-1:0] w_nxt;
    logic          w_load;

    // Synchroniser chain plus the delay flop used for edge detection.
    // Both are frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_d <= '0;
        end else if (ena) begin
            r_sync[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_d <= r_sync[STAGES-1];
        end
    end

    assign w_last = r_sync[STAGES-1];

    if (EDGE_MODE == 0) begin : g_rise
        assign w_raw_edge = w_last & ~r_d;
    end else if (EDGE_MODE == 1) begin : g_fall
        assign w_raw_edge = ~w_last & r_d;
    end else begin : g_both
        assign w_raw_edge = w_last ^ r_d;
    end

    // A frozen chain can hold last != d indefinitely. Gating stops that
    // difference from firing once per clock. The edge is taken on the first
    // clock after ena returns.
    assign w_edge = ena ? w_raw_edge : '0;

    assign w_nxt  = r_pending | w_edge;
    // The holding register reloads when it is empty or being consumed.
    // This gives back-to-back masks with no bubble cycle.
    assign w_load = !r_evt_valid || evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_evt_data  <= '0;
            r_evt_valid <= 1'b0;
        end else if (w_load) begin
            r_evt_data  <= w_nxt;
            r_evt_valid <= |w_nxt;
            r_pending   <= '0;
        end else begin
            r_pending   <= w_nxt;
        end
    end

    // Overflow means a second edge arrived while the first edge was still in
    // pending. An edge that matches a bit of the stalled evt_data is not an
    // overflow; it simply queues in pending.
    // A new set on the same clock as ovf_clr takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (ovf_clr ? '0 : r_ovf) | (w_edge & r_pending);
        end
    end

    assign sync_out  = w_last;
    assign evt_data  = r_evt_data;
    assign evt_valid = r_evt_valid;
    assign ovf       = r_ovf;

endmodule
